// File: rtl/seg_scan_capture_if.sv
// Bus between a 7-segment display scanner and the capture block that reads it back.
// The scanner side (master) drives the anode/segment/dp lines; the capture side
// (slave) returns the rebuilt frame plus status and debug visibility.
//
// Transfer semantics: there is no backpressure. frame_valid is a one-clk pulse;
// value, dp_out and frame_err change only on that clk and hold until the next
// pulse, so a consumer may sample them on the pulse or any time afterwards.
interface seg_scan_capture_if;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] value;
    logic [7:0]  dp_out;
    logic        frame_valid;
    logic        frame_err;
    logic        stale;
    logic [1:0]  state_dbg;
    logic [7:0]  mask_dbg;

    modport master (
        output an, seg, dp,
        input  value, dp_out, frame_valid, frame_err, stale, state_dbg, mask_dbg
    );

    modport slave (
        input  an, seg, dp,
        output value, dp_out, frame_valid, frame_err, stale, state_dbg, mask_dbg
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Reader for a multiplexed 8-digit 7-segment bus. Synchronizes the scanned lines,
// waits for each selected digit to settle, decodes the glyph to a hex nibble and
// assembles a 32-bit frame once all eight digits have been seen. Non-hex glyphs
// flag the frame; a scan that stops producing frames raises stale.
module seg_scan_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 262144
) (
    input logic            clk,
    input logic            reset,
    seg_scan_capture_if.slave bus
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    // Exactly one anode low selects a digit; blank or multi-select is ignored.
    function automatic logic is_legal(input logic [7:0] a);
        logic [7:0] sel;
        sel = ~a;
        return (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    endfunction

    logic [7:0]  an_s1, an_s2, an_q;
    logic [6:0]  seg_s1, seg_s2, seg_q;
    logic        dp_s1, dp_s2, dp_q;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        cap_en;
    logic        sample_changed;
    logic        an_changed;

    logic [3:0]  dec_nib;
    logic        dec_err;
    logic [2:0]  dec_idx;

    logic [2:0]  cap_idx;
    logic [3:0]  cap_nib;
    logic        cap_err;
    logic        cap_dp;

    logic [31:0] shadow_val;
    logic [7:0]  shadow_dp;
    logic [7:0]  mask_q;
    logic [7:0]  mask_set;
    logic        err_acc;
    logic        frame_done;

    logic [31:0] value_q;
    logic [7:0]  dp_out_q;
    logic        frame_valid_q;
    logic        frame_err_q;
    logic [TW-1:0] tmo_q;

    // Two-flop synchronizer plus one extra stage holding the previous sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_s1  <= 8'hFF;
            an_s2  <= 8'hFF;
            an_q   <= 8'hFF;
            seg_s1 <= 7'h7F;
            seg_s2 <= 7'h7F;
            seg_q  <= 7'h7F;
            dp_s1  <= 1'b1;
            dp_s2  <= 1'b1;
            dp_q   <= 1'b1;
        end else begin
            an_s1  <= bus.an;
            an_s2  <= an_s1;
            an_q   <= an_s2;
            seg_s1 <= bus.seg;
            seg_s2 <= seg_s1;
            seg_q  <= seg_s2;
            dp_s1  <= bus.dp;
            dp_s2  <= dp_s1;
            dp_q   <= dp_s2;
        end
    end

    assign sample_changed = {an_s2, seg_s2, dp_s2} != {an_q, seg_q, dp_q};
    assign an_changed     = an_s2 != an_q;

    // Glyph decode and digit index of the previous (already compared) sample.
    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        dec_idx = 3'd0;
        case (seg_q)
            7'h01: dec_nib = 4'h0;
            7'h4F: dec_nib = 4'h1;
            7'h12: dec_nib = 4'h2;
            7'h06: dec_nib = 4'h3;
            7'h4C: dec_nib = 4'h4;
            7'h24: dec_nib = 4'h5;
            7'h20: dec_nib = 4'h6;
            7'h0F: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h04: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h60: dec_nib = 4'hB;
            7'h31: dec_nib = 4'hC;
            7'h42: dec_nib = 4'hD;
            7'h30: dec_nib = 4'hE;
            7'h38: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_err = 1'b1;
            end
        endcase
        for (int i = 0; i < 8; i++) begin
            if (!an_q[i]) dec_idx = 3'(i);
        end
    end

    // Capture FSM state and settle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: settle on a stable digit, capture once, wait for the scan to move.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_legal(an_s2)) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_CAPTURE;
                end else if (sample_changed) begin
                    if (is_legal(an_s2)) cnt_d = CNT_ONE;
                    else                 state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_CAPTURE: begin
                cap_en  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (an_changed) begin
                    if (is_legal(an_s2)) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mask_set = mask_q | (8'h01 << cap_idx);

    // Frame assembly: latch the settled digit, write its slot, publish full frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_idx       <= 3'd0;
            cap_nib       <= 4'h0;
            cap_err       <= 1'b0;
            cap_dp        <= 1'b0;
            shadow_val    <= 32'h0;
            shadow_dp     <= 8'h00;
            mask_q        <= 8'h00;
            err_acc       <= 1'b0;
            frame_done    <= 1'b0;
            value_q       <= 32'h0;
            dp_out_q      <= 8'h00;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_done    <= 1'b0;
            // The previous sample was the last one proven stable, so it is what gets kept.
            if (state_q == ST_SETTLE && state_d == ST_CAPTURE) begin
                cap_idx <= dec_idx;
                cap_nib <= dec_nib;
                cap_err <= dec_err;
                cap_dp  <= ~dp_q;
            end
            if (cap_en) begin
                shadow_val[{cap_idx, 2'b00} +: 4] <= cap_nib;
                shadow_dp[cap_idx]                <= cap_dp;
                mask_q                            <= mask_set;
                err_acc                           <= err_acc | cap_err;
                frame_done                        <= (mask_set == 8'hFF);
            end
            if (frame_done) begin
                value_q       <= shadow_val;
                dp_out_q      <= shadow_dp;
                frame_err_q   <= err_acc;
                frame_valid_q <= 1'b1;
                mask_q        <= 8'h00;
                err_acc       <= 1'b0;
            end
        end
    end

    // Stall detector: saturating count of clks since the last published frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (frame_done) begin
            tmo_q <= '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    assign bus.value       = value_q;
    assign bus.dp_out      = dp_out_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.stale       = (tmo_q == TMO_MAX);
    assign bus.state_dbg   = state_q;
    assign bus.mask_dbg    = mask_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: drives scanned digits onto the bus and checks
// rebuilt frames, dp, glyph errors, settle filtering, async reset and stale detection.
module tb_seg_scan_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 300;
    localparam int DWELL   = 20;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    seg_scan_capture_if bus();

    seg_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame monitor, sampled on the falling edge.
    int          fv_count = 0;
    int          fv_long  = 0;
    logic        fv_prev  = 1'b0;
    logic [31:0] fv_value = 32'h0;
    logic [7:0]  fv_dp    = 8'h00;
    logic        fv_err   = 1'b0;
    logic        fv_stale = 1'b0;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            fv_count = fv_count + 1;
            fv_value = bus.value;
            fv_dp    = bus.dp_out;
            fv_err   = bus.frame_err;
            fv_stale = bus.stale;
            if (fv_prev) fv_long = fv_long + 1;
        end
        fv_prev = (bus.frame_valid === 1'b1);
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] g, input logic dp_n, input int dwell);
        logic [7:0] sel;
        sel    = 8'h01 << d;
        bus.an  = ~sel;
        bus.seg = g;
        bus.dp  = dp_n;
        step(dwell);
    endtask

    task automatic scan_frame(input logic [31:0] word, input logic [7:0] dps, input int bad_digit);
        for (int d = 0; d < 8; d++) begin
            if (d == bad_digit) show(d, 7'h7F, ~dps[d], DWELL);
            else                show(d, glyph[word[4*d +: 4]], ~dps[d], DWELL);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.an  = 8'hFF;
        bus.seg = 7'h7F;
        bus.dp  = 1'b1;
        step(3);
        checks++; if (bus.value !== 32'h0) begin failures++; $display("FAIL reset_value: got %h expected %h", bus.value, 32'h0); end
        checks++; if (bus.dp_out !== 8'h00) begin failures++; $display("FAIL reset_dp_out: got %h expected %h", bus.dp_out, 8'h00); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid: got %b expected 0", bus.frame_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.stale !== 1'b0) begin failures++; $display("FAIL reset_stale: got %b expected 0", bus.stale); end
        checks++; if (bus.mask_dbg !== 8'h00) begin failures++; $display("FAIL reset_mask: got %h expected %h", bus.mask_dbg, 8'h00); end
        checks++; if (bus.state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg); end
        reset = 1'b0;
        step(3);
    endtask

    task automatic test_basic_frame();
        int n0;
        n0 = fv_count;
        scan_frame(32'h12345678, 8'h00, -1);
        checks++; if (fv_count - n0 != 1) begin failures++; $display("FAIL basic_pulses: got %0d expected 1", fv_count - n0); end
        checks++; if (fv_value !== 32'h12345678) begin failures++; $display("FAIL basic_value: got %h expected %h", fv_value, 32'h12345678); end
        checks++; if (fv_err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b expected 0", fv_err); end
        checks++; if (fv_dp !== 8'h00) begin failures++; $display("FAIL basic_dp: got %h expected %h", fv_dp, 8'h00); end
        checks++; if (fv_long != 0) begin failures++; $display("FAIL basic_pulse_width: got %0d long pulses expected 0", fv_long); end
        checks++; if (bus.value !== 32'h12345678) begin failures++; $display("FAIL basic_value_held: got %h expected %h", bus.value, 32'h12345678); end
    endtask

    task automatic test_dp_glyph_f();
        int n0;
        n0 = fv_count;
        scan_frame(32'hFFFFFFFF, 8'h08, -1);
        checks++; if (fv_count - n0 != 1) begin failures++; $display("FAIL dp_pulses: got %0d expected 1", fv_count - n0); end
        checks++; if (fv_value !== 32'hFFFFFFFF) begin failures++; $display("FAIL dp_value: got %h expected %h", fv_value, 32'hFFFFFFFF); end
        checks++; if (bus.dp_out !== 8'h08) begin failures++; $display("FAIL dp_out: got %h expected %h", bus.dp_out, 8'h08); end
    endtask

    task automatic test_glyph_error();
        int n0;
        n0 = fv_count;
        scan_frame(32'h00000000, 8'h00, 5);
        checks++; if (fv_count - n0 != 1) begin failures++; $display("FAIL gerr_pulses: got %0d expected 1", fv_count - n0); end
        checks++; if (fv_err !== 1'b1) begin failures++; $display("FAIL gerr_flag: got %b expected 1", fv_err); end
        checks++; if (fv_value !== 32'h0) begin failures++; $display("FAIL gerr_value: got %h expected %h", fv_value, 32'h0); end
        scan_frame(32'h89ABCDEF, 8'h00, -1);
        checks++; if (fv_count - n0 != 2) begin failures++; $display("FAIL gerr_clean_pulses: got %0d expected 2", fv_count - n0); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL gerr_cleared: got %b expected 0", bus.frame_err); end
        checks++; if (bus.value !== 32'h89ABCDEF) begin failures++; $display("FAIL gerr_clean_value: got %h expected %h", bus.value, 32'h89ABCDEF); end
    endtask

    task automatic test_settle_filter();
        int n0;
        n0 = fv_count;
        bus.an = 8'hFE;
        bus.dp = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.seg = (k % 2 == 0) ? glyph[0] : glyph[1];
            step(2);
            checks++; if (bus.mask_dbg !== 8'h00) begin failures++; $display("FAIL settle_toggle_mask[%0d]: got %h expected %h", k, bus.mask_dbg, 8'h00); end
        end
        bus.seg = glyph[3];
        step(2);
        checks++; if (bus.mask_dbg !== 8'h00) begin failures++; $display("FAIL settle_early_mask: got %h expected %h", bus.mask_dbg, 8'h00); end
        step(15);
        checks++; if (bus.mask_dbg !== 8'h01) begin failures++; $display("FAIL settle_captured_mask: got %h expected %h", bus.mask_dbg, 8'h01); end
        for (int d = 1; d < 8; d++) show(d, glyph[d], 1'b1, DWELL);
        checks++; if (fv_count - n0 != 1) begin failures++; $display("FAIL settle_pulses: got %0d expected 1", fv_count - n0); end
        checks++; if (fv_value !== 32'h76543213) begin failures++; $display("FAIL settle_value: got %h expected %h", fv_value, 32'h76543213); end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        for (int d = 0; d < 4; d++) show(d, glyph[9], 1'b1, DWELL);
        checks++; if (bus.mask_dbg !== 8'h0F) begin failures++; $display("FAIL mid_partial_mask: got %h expected %h", bus.mask_dbg, 8'h0F); end
        #2;
        reset  = 1'b1;
        bus.an = 8'hFF;
        #1;
        checks++; if (bus.value !== 32'h0) begin failures++; $display("FAIL mid_async_value: got %h expected %h", bus.value, 32'h0); end
        checks++; if (bus.dp_out !== 8'h00) begin failures++; $display("FAIL mid_async_dp: got %h expected %h", bus.dp_out, 8'h00); end
        checks++; if (bus.mask_dbg !== 8'h00) begin failures++; $display("FAIL mid_async_mask: got %h expected %h", bus.mask_dbg, 8'h00); end
        step(2);
        reset = 1'b0;
        step(2);
        n0 = fv_count;
        scan_frame(32'hCAFE0123, 8'h00, -1);
        checks++; if (fv_count - n0 != 1) begin failures++; $display("FAIL mid_pulses: got %0d expected 1", fv_count - n0); end
        checks++; if (fv_value !== 32'hCAFE0123) begin failures++; $display("FAIL mid_value: got %h expected %h", fv_value, 32'hCAFE0123); end
    endtask

    task automatic test_stale();
        int n0;
        logic [31:0] word;
        word    = 32'hA5A55A5A;
        bus.an  = 8'hFF;
        bus.seg = 7'h7F;
        bus.dp  = 1'b1;
        step(TIMEOUT - 50);
        checks++; if (bus.stale !== 1'b0) begin failures++; $display("FAIL stale_early: got %b expected 0", bus.stale); end
        step(60);
        checks++; if (bus.stale !== 1'b1) begin failures++; $display("FAIL stale_set: got %b expected 1", bus.stale); end
        n0 = fv_count;
        for (int d = 0; d < 7; d++) show(d, glyph[word[4*d +: 4]], 1'b1, DWELL);
        checks++; if (bus.stale !== 1'b1) begin failures++; $display("FAIL stale_partial: got %b expected 1", bus.stale); end
        checks++; if (bus.mask_dbg !== 8'h7F) begin failures++; $display("FAIL stale_partial_mask: got %h expected %h", bus.mask_dbg, 8'h7F); end
        show(7, glyph[word[31:28]], 1'b1, DWELL);
        checks++; if (fv_count - n0 != 1) begin failures++; $display("FAIL stale_pulses: got %0d expected 1", fv_count - n0); end
        checks++; if (fv_stale !== 1'b0) begin failures++; $display("FAIL stale_on_valid: got %b expected 0", fv_stale); end
        checks++; if (fv_value !== word) begin failures++; $display("FAIL stale_value: got %h expected %h", fv_value, word); end
        checks++; if (bus.stale !== 1'b0) begin failures++; $display("FAIL stale_after: got %b expected 0", bus.stale); end
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_basic_frame();
        test_dp_glyph_f();
        test_glyph_error();
        test_settle_filter();
        test_reset_mid_frame();
        test_stale();
        checks++; if (fv_long != 0) begin failures++; $display("FAIL frame_valid_width: got %0d long pulses expected 0", fv_long); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
